tlul_err_resp: RTL and testbench

- Parametrised TL-UL error filter and responder placed in front of a device port (e.g. SPI register block).
- Checks each A-channel request for legal opcode, size, alignment and mask for any power-of-two data width.
- Forwards legal requests to the device and absorbs illegal ones, returning its own d_error=1 response in correct order.
- Tracks downstream outstanding transactions so that error responses never overtake device responses.

---
 rtl/tluh_32_pkg.sv | 48 ++++
 rtl/tlul_req_chk.sv | 31 +++
 rtl/tlul_err_resp.sv | 142 ++++++++++++++
 tb/tb_tlul_err_resp.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tluh_32_pkg.sv
// TL-UL shared types and request legality helper.
// Pure package: no logic, no latency.
// No flow control: consumers apply the helper combinationally.
package tluh_32_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  // Widest bus the helper covers (512-bit data) and widest size/offset field.
  localparam int unsigned TlMaxMW  = 64;
  localparam int unsigned TlMaxSzW = 8;

  // Callers zero-extend size, low address bits and mask to the maximum widths
  // and pass their own log2(bytes per beat) as sub_aw.
  function automatic logic tl_req_legal(
    input logic [2:0]          opcode,
    input logic [TlMaxSzW-1:0] size,
    input logic [TlMaxSzW-1:0] addr_lo,
    input logic [TlMaxMW-1:0]  mask,
    input int unsigned         sub_aw
  );
    logic        op_ok, size_ok, align_ok, mask_ok;
    int unsigned lo, hi;
    op_ok    = (opcode == Get) || (opcode == PutFullData) || (opcode == PutPartialData);
    size_ok  = (32'(size) <= sub_aw);
    lo       = 32'(addr_lo);
    hi       = size_ok ? lo + (32'd1 << size) : lo;
    align_ok = size_ok ? ((lo & ((32'd1 << size) - 32'd1)) == 32'd0) : 1'b0;
    mask_ok  = 1'b1;
    for (int unsigned i = 0; i < TlMaxMW; i++) begin
      if (i < lo || i >= hi) begin
        if (mask[i]) mask_ok = 1'b0;
      end else if (opcode == PutFullData && !mask[i]) begin
        mask_ok = 1'b0;
      end
    end
    return op_ok && size_ok && align_ok && mask_ok;
  endfunction

endpackage

// File: rtl/tlul_req_chk.sv
// Combinational TL-UL A-channel legality check (opcode, size, alignment, mask).
// Latency: zero cycles.
// No flow control: result is valid whenever the inputs are.
module tlul_req_chk
  import tluh_32_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned SZW = 2,
  localparam int unsigned MW    = DW / 8,
  localparam int unsigned SubAW = $clog2(MW)
) (
  input  logic [2:0]       opcode,
  input  logic [SZW-1:0]   size,
  input  logic [SubAW-1:0] addr_lo,
  input  logic [MW-1:0]    mask,
  output logic             legal
);

  logic [TlMaxSzW-1:0] size_x, addr_x;
  logic [TlMaxMW-1:0]  mask_x;

  assign size_x = TlMaxSzW'(size);
  assign addr_x = TlMaxSzW'(addr_lo);
  assign mask_x = TlMaxMW'(mask);

  // Evaluate the shared helper on zero-extended fields.
  always_comb begin
    legal = tl_req_legal(opcode, size_x, addr_x, mask_x, SubAW);
  end

endmodule

// File: rtl/tlul_err_resp.sv
// TL-UL error filter: forwards legal requests, answers illegal ones with d_error=1.
// Latency: forwarded path 0 cycles; error response 1 cycle after A acceptance.
// Backpressure: A gated by outstanding count; illegal requests wait for drain; error held until d_ready_i.
module tlul_err_resp
  import tluh_32_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned IW             = 8,
  parameter int unsigned SZW            = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned MW    = DW / 8,
  localparam int unsigned SubAW = $clog2(MW)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           a_valid_i,
  output logic           a_ready_o,
  input  logic [2:0]     a_opcode_i,
  input  logic [SZW-1:0] a_size_i,
  input  logic [AW-1:0]  a_address_i,
  input  logic [MW-1:0]  a_mask_i,
  input  logic [IW-1:0]  a_source_i,
  output logic           dev_a_valid_o,
  input  logic           dev_a_ready_i,
  input  logic           dev_d_valid_i,
  output logic           dev_d_ready_o,
  input  logic [2:0]     dev_d_opcode_i,
  input  logic [SZW-1:0] dev_d_size_i,
  input  logic [IW-1:0]  dev_d_source_i,
  input  logic           dev_d_error_i,
  input  logic [DW-1:0]  dev_d_data_i,
  output logic           d_valid_o,
  input  logic           d_ready_i,
  output logic [2:0]     d_opcode_o,
  output logic [SZW-1:0] d_size_o,
  output logic [IW-1:0]  d_source_o,
  output logic           d_error_o,
  output logic [DW-1:0]  d_data_o,
  output logic           chk_err_o,
  output logic           unexp_rsp_o
);

  localparam int unsigned CW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, ERR_RSP} state_e;

  state_e         state, state_nxt;
  logic [CW-1:0]  out_cnt;
  logic [IW-1:0]  err_source;
  logic [SZW-1:0] err_size;
  logic           err_is_get;
  logic           legal, cnt_open, err_accept, dev_a_hs, dev_d_hs;
  logic           unused_addr;

  // Upper address bits travel to the device on its own wiring; only the offset is checked here.
  assign unused_addr = ^a_address_i[AW-1:SubAW];

  tlul_req_chk #(.DW(DW), .SZW(SZW)) u_req_chk (
    .opcode  (a_opcode_i),
    .size    (a_size_i),
    .addr_lo (a_address_i[SubAW-1:0]),
    .mask    (a_mask_i),
    .legal   (legal)
  );

  assign chk_err_o = a_valid_i & ~legal;
  assign cnt_open  = (out_cnt < CW'(MaxOutstanding));

  // Next state, channel gating and D-channel mux.
  always_comb begin
    state_nxt     = state;
    a_ready_o     = 1'b0;
    dev_a_valid_o = 1'b0;
    dev_d_ready_o = 1'b0;
    d_valid_o     = 1'b0;
    d_opcode_o    = dev_d_opcode_i;
    d_size_o      = dev_d_size_i;
    d_source_o    = dev_d_source_i;
    d_error_o     = dev_d_error_i;
    d_data_o      = dev_d_data_i;
    err_accept    = 1'b0;
    unique case (state)
      IDLE: begin
        d_valid_o     = dev_d_valid_i;
        dev_d_ready_o = d_ready_i;
        if (legal) begin
          dev_a_valid_o = a_valid_i & cnt_open & ~rst_i;
          a_ready_o     = dev_a_ready_i & cnt_open & ~rst_i;
        end else begin
          // Illegal requests wait until every forwarded request has been answered.
          a_ready_o  = (out_cnt == '0) & ~rst_i;
          err_accept = a_valid_i & a_ready_o;
          if (err_accept) state_nxt = ERR_RSP;
        end
      end
      ERR_RSP: begin
        d_valid_o  = 1'b1;
        d_error_o  = 1'b1;
        d_opcode_o = err_is_get ? AccessAckData : AccessAck;
        d_size_o   = err_size;
        d_source_o = err_source;
        d_data_o   = '1;
        if (d_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dev_a_hs    = dev_a_valid_o & dev_a_ready_i;
  assign dev_d_hs    = dev_d_valid_i & dev_d_ready_o;
  assign unexp_rsp_o = dev_d_hs & (out_cnt == '0);

  // State register and captured fields of the request being answered with an error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      err_source <= '0;
      err_size   <= '0;
      err_is_get <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_accept) begin
        err_source <= a_source_i;
        err_size   <= a_size_i;
        err_is_get <= (a_opcode_i == Get);
      end
    end
  end

  // Outstanding forwarded requests; a response with nothing outstanding leaves it at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt <= '0;
    end else if (dev_a_hs && !(dev_d_hs && out_cnt != '0)) begin
      out_cnt <= out_cnt + 1'b1;
    end else if (!dev_a_hs && dev_d_hs && out_cnt != '0) begin
      out_cnt <= out_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_tlul_err_resp.sv
module tb_tlul_err_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // 32-bit instance
  logic a_valid, a_ready, dev_a_valid, dev_a_ready, dev_d_valid, dev_d_ready;
  logic d_valid, d_ready, d_error, dev_d_error, chk_err, unexp;
  logic [2:0] a_opcode, dev_d_opcode, d_opcode;
  logic [1:0] a_size, dev_d_size, d_size;
  logic [31:0] a_address, dev_d_data, d_data;
  logic [3:0] a_mask;
  logic [7:0] a_source, dev_d_source, d_source;

  // 64-bit instance
  logic w_a_valid, w_a_ready, w_dev_a_valid, w_dev_a_ready, w_dev_d_valid, w_dev_d_ready;
  logic w_d_valid, w_d_ready, w_d_error, w_dev_d_error, w_chk_err, w_unexp;
  logic [2:0] w_a_opcode, w_dev_d_opcode, w_d_opcode;
  logic [1:0] w_a_size, w_dev_d_size, w_d_size;
  logic [31:0] w_a_address;
  logic [63:0] w_dev_d_data, w_d_data;
  logic [7:0] w_a_mask, w_a_source, w_dev_d_source, w_d_source;

  tlul_err_resp #(.DW(32)) dut32 (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_size_i(a_size),
    .a_address_i(a_address), .a_mask_i(a_mask), .a_source_i(a_source),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready),
    .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready), .dev_d_opcode_i(dev_d_opcode),
    .dev_d_size_i(dev_d_size), .dev_d_source_i(dev_d_source), .dev_d_error_i(dev_d_error),
    .dev_d_data_i(dev_d_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_size_o(d_size),
    .d_source_o(d_source), .d_error_o(d_error), .d_data_o(d_data),
    .chk_err_o(chk_err), .unexp_rsp_o(unexp)
  );

  tlul_err_resp #(.DW(64)) dut64 (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(w_a_valid), .a_ready_o(w_a_ready), .a_opcode_i(w_a_opcode), .a_size_i(w_a_size),
    .a_address_i(w_a_address), .a_mask_i(w_a_mask), .a_source_i(w_a_source),
    .dev_a_valid_o(w_dev_a_valid), .dev_a_ready_i(w_dev_a_ready),
    .dev_d_valid_i(w_dev_d_valid), .dev_d_ready_o(w_dev_d_ready), .dev_d_opcode_i(w_dev_d_opcode),
    .dev_d_size_i(w_dev_d_size), .dev_d_source_i(w_dev_d_source), .dev_d_error_i(w_dev_d_error),
    .dev_d_data_i(w_dev_d_data),
    .d_valid_o(w_d_valid), .d_ready_i(w_d_ready), .d_opcode_o(w_d_opcode), .d_size_o(w_d_size),
    .d_source_o(w_d_source), .d_error_o(w_d_error), .d_data_o(w_d_data),
    .chk_err_o(w_chk_err), .unexp_rsp_o(w_unexp)
  );

  typedef struct {
    logic [2:0] op;
    logic [1:0] size;
    logic [1:0] addr;
    logic [3:0] mask;
    logic       exp_chk;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge (one full cycle, crossing one rising edge).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [7:0] src);
    a_opcode = op; a_size = sz; a_address = addr; a_mask = mask; a_source = src;
    a_valid = 1'b1;
  endtask

  initial begin
    a_valid = 0; a_opcode = 0; a_size = 0; a_address = 0; a_mask = 0; a_source = 0;
    dev_a_ready = 0; dev_d_valid = 0; dev_d_opcode = 0; dev_d_size = 0; dev_d_source = 0;
    dev_d_error = 0; dev_d_data = 0; d_ready = 0;
    w_a_valid = 0; w_a_opcode = 0; w_a_size = 0; w_a_address = 0; w_a_mask = 0; w_a_source = 0;
    w_dev_a_ready = 0; w_dev_d_valid = 0; w_dev_d_opcode = 0; w_dev_d_size = 0; w_dev_d_source = 0;
    w_dev_d_error = 0; w_dev_d_data = 0; w_d_ready = 0;

    //               op    size  addr  mask     illegal
    vecs[0]  = '{3'd4, 2'd1, 2'd2, 4'b1100, 1'b0}; // Get upper half
    vecs[1]  = '{3'd0, 2'd2, 2'd0, 4'b0111, 1'b1}; // PutFull missing lane
    vecs[2]  = '{3'd0, 2'd2, 2'd0, 4'b1111, 1'b0}; // PutFull word
    vecs[3]  = '{3'd1, 2'd2, 2'd0, 4'b0101, 1'b0}; // PutPartial sparse
    vecs[4]  = '{3'd4, 2'd3, 2'd0, 4'b1111, 1'b1}; // size too big
    vecs[5]  = '{3'd4, 2'd1, 2'd1, 4'b0110, 1'b1}; // misaligned
    vecs[6]  = '{3'd3, 2'd2, 2'd0, 4'b1111, 1'b1}; // bad opcode
    vecs[7]  = '{3'd1, 2'd0, 2'd1, 4'b0010, 1'b0}; // PutPartial byte
    vecs[8]  = '{3'd1, 2'd0, 2'd1, 4'b0011, 1'b1}; // lane outside window
    vecs[9]  = '{3'd0, 2'd1, 2'd2, 4'b0100, 1'b1}; // PutFull half, lane missing
    vecs[10] = '{3'd4, 2'd0, 2'd3, 4'b0000, 1'b0}; // Get, empty mask allowed
    vecs[11] = '{3'd2, 2'd2, 2'd0, 4'b1111, 1'b1}; // arithmetic opcode

    // Reset state
    #2;
    check("rst_d_valid", d_valid, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_dev_a_valid", dev_a_valid, 0);
    check("rst_unexp", unexp, 0);
    check("rst_out_cnt", dut32.out_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Legality table: presented between rising edges so no handshake happens.
    dev_a_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_a(vecs[i].op, vecs[i].size, 32'h1000 | 32'(vecs[i].addr), vecs[i].mask, 8'h00);
      #1;
      check($sformatf("vec%0d_chk_err", i), chk_err, vecs[i].exp_chk);
      check($sformatf("vec%0d_dev_a_valid", i), dev_a_valid, !vecs[i].exp_chk);
      check($sformatf("vec%0d_a_ready", i), a_ready, 1);
      a_valid = 1'b0;
      tick();
    end

    // Forwarded Get and pass-through response
    drive_a(3'd4, 2'd1, 32'h1002, 4'b1100, 8'h11);
    #1;
    check("fwd_dev_a_valid", dev_a_valid, 1);
    check("fwd_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("fwd_cnt1", dut32.out_cnt, 1);
    dev_d_valid = 1; dev_d_opcode = 3'd1; dev_d_size = 2'd1; dev_d_source = 8'h11;
    dev_d_data = 32'hDEADBEEF; d_ready = 1;
    #1;
    check("fwd_d_valid", d_valid, 1);
    check("fwd_d_error", d_error, 0);
    check("fwd_d_opcode", d_opcode, 1);
    check("fwd_d_source", d_source, 8'h11);
    check("fwd_d_data", d_data, 32'hDEADBEEF);
    check("fwd_dev_d_ready", dev_d_ready, 1);
    check("fwd_unexp", unexp, 0);
    tick();
    dev_d_valid = 0;
    check("fwd_cnt0", dut32.out_cnt, 0);

    // Illegal PutFull answered locally
    d_ready = 0;
    drive_a(3'd0, 2'd2, 32'h1000, 4'b0111, 8'h22);
    #1;
    check("err_chk", chk_err, 1);
    check("err_no_dev_a", dev_a_valid, 0);
    check("err_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    #1;
    check("err_d_valid", d_valid, 1);
    check("err_d_error", d_error, 1);
    check("err_d_opcode", d_opcode, 0);
    check("err_d_source", d_source, 8'h22);
    check("err_d_size", d_size, 2);
    check("err_d_data", d_data, 32'hFFFFFFFF);
    check("err_a_ready_busy", a_ready, 0);
    check("err_dev_d_ready", dev_d_ready, 0);
    tick();
    check("err_hold_valid", d_valid, 1);
    check("err_hold_source", d_source, 8'h22);
    d_ready = 1;
    tick();
    check("err_done", d_valid, 0);

    // 64-bit misaligned Get
    w_a_opcode = 3'd4; w_a_size = 2'd3; w_a_address = 32'h4; w_a_mask = 8'hFF;
    w_a_source = 8'h33; w_a_valid = 1; w_dev_a_ready = 1; w_d_ready = 0;
    #1;
    check("w_chk", w_chk_err, 1);
    check("w_no_dev_a", w_dev_a_valid, 0);
    check("w_a_ready", w_a_ready, 1);
    tick();
    w_a_valid = 0;
    #1;
    check("w_d_valid", w_d_valid, 1);
    check("w_d_error", w_d_error, 1);
    check("w_d_opcode", w_d_opcode, 1);
    check("w_d_size", w_d_size, 3);
    check("w_d_source", w_d_source, 8'h33);
    check("w_d_data", w_d_data, 64'hFFFF_FFFF_FFFF_FFFF);
    w_d_ready = 1;
    tick();
    check("w_done", w_d_valid, 0);

    // Ordering with outstanding requests (device D withheld)
    d_ready = 1; dev_d_opcode = 3'd1; dev_d_size = 2'd2; dev_d_data = 32'h0;
    for (int s = 1; s <= 2; s++) begin
      drive_a(3'd4, 2'd2, 32'h2000, 4'b1111, 8'(s));
      tick();
    end
    check("ord_cnt2", dut32.out_cnt, 2);
    drive_a(3'd4, 2'd2, 32'h2000, 4'b1111, 8'd3);
    #1;
    check("full_a_ready", a_ready, 0);
    check("full_dev_a_valid", dev_a_valid, 0);
    tick();
    check("full_cnt_held", dut32.out_cnt, 2);
    dev_d_valid = 1; dev_d_source = 8'd1;
    #1;
    check("full_dev_a_gate", dev_a_valid, 0);
    check("ord_rsp1_src", d_source, 8'd1);
    tick();
    check("ord_cnt1", dut32.out_cnt, 1);
    dev_d_source = 8'd2;
    #1;
    check("sim_dev_a_valid", dev_a_valid, 1);
    check("sim_a_ready", a_ready, 1);
    check("ord_rsp2_src", d_source, 8'd2);
    tick();
    check("sim_cnt_kept", dut32.out_cnt, 1);
    dev_d_valid = 0;
    drive_a(3'd3, 2'd2, 32'h2000, 4'b1111, 8'd4);
    #1;
    check("stall_chk", chk_err, 1);
    check("stall_a_ready", a_ready, 0);
    check("stall_dev_a", dev_a_valid, 0);
    tick();
    dev_d_valid = 1; dev_d_source = 8'd3;
    #1;
    check("drain_d_valid", d_valid, 1);
    check("drain_d_error", d_error, 0);
    check("drain_d_source", d_source, 8'd3);
    check("drain_a_ready", a_ready, 0);
    tick();
    dev_d_valid = 0;
    #1;
    check("drain_cnt0", dut32.out_cnt, 0);
    check("drained_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    #1;
    check("ord_err_valid", d_valid, 1);
    check("ord_err_error", d_error, 1);
    check("ord_err_opcode", d_opcode, 0);
    check("ord_err_source", d_source, 8'd4);
    tick();

    // Reset while an error response is pending
    d_ready = 0;
    drive_a(3'd4, 2'd3, 32'h1000, 4'b1111, 8'd5);
    tick();
    a_valid = 0;
    #1;
    check("pre_rst_valid", d_valid, 1);
    check("pre_rst_opcode", d_opcode, 1);
    rst = 1;
    #1;
    check("in_rst_d_valid", d_valid, 0);
    check("in_rst_a_ready", a_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_cnt", dut32.out_cnt, 0);
    check("post_rst_d_valid", d_valid, 0);
    dev_d_valid = 1; d_ready = 1; dev_d_source = 8'd9;
    #1;
    check("unexp_pulse", unexp, 1);
    check("unexp_passthru", d_valid, 1);
    tick();
    dev_d_valid = 0;
    #1;
    check("unexp_cleared", unexp, 0);
    check("unexp_cnt0", dut32.out_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
